// File: rtl/link_tx_arbiter.sv
// Output side of one router link: round-robin arbitration over input
// buffers with wormhole locking, one registered flit per cycle.
module link_tx_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            req,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_INPUTS-1:0]            grant,
    input  logic                             buffer_full,
    output logic                             sending_data,
    output logic [DATA_WIDTH-1:0]            data_out
);

    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         owner_q;
    logic                  sending_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic [IW:0]           scan_sum;
    logic [IW-1:0]         scan_cand;
    logic [IW-1:0]         scan_idx;
    logic                  scan_vld;
    logic [IW-1:0]         sel_idx;
    logic                  sel_vld;
    logic                  launch;
    logic [DATA_WIDTH-1:0] sel_flit;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        if (p == IW'(NUM_INPUTS - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Round-robin scan: walk downwards so the closest requester to rr_ptr wins last.
    always_comb begin
        scan_vld  = 1'b0;
        scan_idx  = '0;
        scan_sum  = '0;
        scan_cand = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NUM_INPUTS)) begin
                scan_sum = scan_sum - (IW+1)'(NUM_INPUTS);
            end
            scan_cand = scan_sum[IW-1:0];
            if (req[scan_cand]) begin
                scan_vld = 1'b1;
                scan_idx = scan_cand;
            end
        end
    end

    // While a packet holds the link only its owner may be selected.
    always_comb begin
        sel_vld = scan_vld;
        sel_idx = scan_idx;
        if (state_q == LOCKED) begin
            sel_vld = req[owner_q];
            sel_idx = owner_q;
        end
    end

    assign launch   = rst & ~buffer_full & sel_vld;
    assign sel_flit = data_in[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

    // One-hot pop pulse toward the selected input buffer.
    always_comb begin
        grant          = '0;
        grant[sel_idx] = launch;
    end

    // Arbitration FSM plus registered link outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            sending_q <= 1'b0;
            data_q    <= '0;
        end else begin
            sending_q <= launch;
            if (launch) begin
                data_q <= sel_flit;
                if (sel_flit[DATA_WIDTH-1]) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= ptr_inc(sel_idx);
                end else begin
                    state_q <= LOCKED;
                    owner_q <= sel_idx;
                end
            end
        end
    end

    assign sending_data = sending_q;
    assign data_out     = data_q;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: packet-level reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_link_tx_arbiter;

    localparam int NI = 4;
    localparam int DW = 16;

    logic             clk;
    logic             rst;
    logic [NI-1:0]    req;
    logic [NI*DW-1:0] din;
    logic [NI-1:0]    grant;
    logic             bf;
    logic             sending;
    logic [DW-1:0]    dout;

    int total;
    int bad;
    bit check_en;

    // reference model state
    bit          m_locked;
    int          m_owner;
    int          m_rr;
    bit          m_send;
    logic [DW-1:0] m_data;

    link_tx_arbiter #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data_in      (din),
        .grant        (grant),
        .buffer_full  (bf),
        .sending_data (sending),
        .data_out     (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] flit(input int i);
        return din[i*DW +: DW];
    endfunction

    // which input the link serves this cycle, or -1
    function automatic int m_pick();
        if (rst !== 1'b1 || bf) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < NI; k++) begin
            if (req[(m_rr + k) % NI]) return (m_rr + k) % NI;
        end
        return -1;
    endfunction

    function automatic logic [NI-1:0] m_grant();
        int g;
        g = m_pick();
        if (g < 0) return '0;
        return NI'(1) << g;
    endfunction

    always @(posedge clk or negedge rst) begin
        int g;
        if (rst !== 1'b1) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_rr     = 0;
            m_send   = 1'b0;
            m_data   = '0;
        end else begin
            g = m_pick();
            m_send = (g >= 0);
            if (g >= 0) begin
                m_data = flit(g);
                if (flit(g)[DW-1]) begin
                    m_locked = 1'b0;
                    m_rr     = (g + 1) % NI;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_grant", 32'(grant), 32'(m_grant()));
            chk("model_send", 32'(sending), 32'(m_send));
            chk("model_data", 32'(dout), 32'(m_data));
        end
    end

    task automatic set_flit(input int i, input logic [DW-1:0] v);
        din[i*DW +: DW] = v;
    endtask

    task automatic edge_in();
        @(posedge clk);
        #1;
    endtask

    // check grant mid-cycle, then the registered outputs after the edge
    task automatic step(input string name, input logic [NI-1:0] g,
                        input logic s, input logic [DW-1:0] d);
        @(negedge clk);
        chk({name, "_grant"}, 32'(grant), 32'(g));
        edge_in();
        chk({name, "_send"}, 32'(sending), 32'(s));
        chk({name, "_data"}, 32'(dout), 32'(d));
    endtask

    logic [NI-1:0] rr_seq [5];

    initial begin
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_send   = 1'b0;
        m_data   = '0;
        rst = 1'b0;
        req = '0;
        din = '0;
        bf  = 1'b0;
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;
        req = 4'b1111;
        #2;
        check_en = 1'b1;
        edge_in();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_send", 32'(sending), 32'h0);
        chk("reset_data", 32'(dout), 32'h0);
        req = '0;
        edge_in();
        rst = 1'b1;

        // round robin, all single-flit packets
        for (int i = 0; i < NI; i++) set_flit(i, 16'h8000 | 16'(i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(grant), 32'(rr_seq[k]));
            edge_in();
            chk("rr_send", 32'(sending), 32'h1);
            chk("rr_data", 32'(dout), 32'h8000 | 32'(k % NI));
        end
        req = '0;
        edge_in();

        // wormhole lock: input 1 holds the link over input 0
        set_flit(0, 16'h8000);
        set_flit(1, 16'h0011);
        req = 4'b0011;
        step("worm1", 4'b0010, 1'b1, 16'h0011);
        set_flit(1, 16'h0012);
        step("worm2", 4'b0010, 1'b1, 16'h0012);
        set_flit(1, 16'h8013);
        step("worm3", 4'b0010, 1'b1, 16'h8013);
        req = 4'b0001;
        step("worm4", 4'b0001, 1'b1, 16'h8000);
        req = '0;
        edge_in();

        // single flit
        set_flit(2, 16'h8ABC);
        req = 4'b0100;
        step("single", 4'b0100, 1'b1, 16'h8ABC);
        req = '0;
        edge_in();

        // backpressure mid-packet on input 3
        set_flit(3, 16'h0031);
        req = 4'b1000;
        step("bp_head", 4'b1000, 1'b1, 16'h0031);
        set_flit(3, 16'h0032);
        bf = 1'b1;
        for (int k = 0; k < 3; k++) step("bp_hold", 4'b0000, 1'b0, 16'h0031);
        bf = 1'b0;
        step("bp_resume", 4'b1000, 1'b1, 16'h0032);
        set_flit(3, 16'h8033);
        step("bp_tail", 4'b1000, 1'b1, 16'h8033);
        req = '0;
        edge_in();

        // bubble from owner 0 while input 3 waits
        set_flit(0, 16'h0001);
        set_flit(3, 16'h8333);
        req = 4'b0001;
        step("bub_head", 4'b0001, 1'b1, 16'h0001);
        req = 4'b1000;
        for (int k = 0; k < 2; k++) step("bub_gap", 4'b0000, 1'b0, 16'h0001);
        set_flit(0, 16'h8002);
        req = 4'b1001;
        step("bub_tail", 4'b0001, 1'b1, 16'h8002);
        req = 4'b1000;
        step("bub_next", 4'b1000, 1'b1, 16'h8333);
        req = '0;
        edge_in();

        // reset in the middle of a packet from input 2
        set_flit(2, 16'h0021);
        req = 4'b0100;
        step("rst_head", 4'b0100, 1'b1, 16'h0021);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_send", 32'(sending), 32'h0);
        chk("rst_data", 32'(dout), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        edge_in();
        set_flit(0, 16'h8055);
        set_flit(2, 16'h0022);
        req = 4'b0101;
        rst = 1'b1;
        step("rst_after", 4'b0001, 1'b1, 16'h8055);
        step("rst_after2", 4'b0100, 1'b1, 16'h0022);
        req = '0;
        edge_in();
        edge_in();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
